i2c_slave_regs: RTL and testbench
=================================

// Module: i2c_slave_regs
// PURPOSE
//  I2C target (slave) that answers an I2C master on the shared SCL/SDA bus.
//  It exposes a 2**AW-byte local register space through an auto-incrementing pointer.
//  It sits between the open-drain I2C pads and a local register file, and runs entirely on wb_clk_i.
//  SCL/SDA are oversampled; there is no clock stretching.
// PARAMETERS
//  SLV_ADDR  7'h50  7-bit bus address this target answers to
//  AW        3      register pointer width; register space = 2**AW bytes
//  FILTER    3      consecutive equal samples needed to accept a new SCL/SDA level
// PORTS
//  wb_clk_i      in   1   system clock
//  arst_i        in   1   reset, asynchronous, active-high
//  scl_pad_i     in   1   SCL line
//  sda_pad_i     in   1   SDA line
//  scl_pad_o     out  1   tied 0
//  scl_padoen_o  out  1   tied 1 (SCL never driven)
//  sda_pad_o     out  1   tied 0 (open drain)
//  sda_padoen_o  out  1   0 = pull SDA low, 1 = release
//  reg_adr_o     out  AW  current register pointer
//  reg_dat_o     out  8   write data, valid with reg_we_o
//  reg_we_o      out  1   1-cycle write strobe
//  reg_dat_i     in   8   read data for reg_adr_o (combinational in the register file)
//  busy_o        out  1   1 from START detect until STOP detect
// BEHAVIOUR
//  Reset (arst_i=1, async): sda_padoen_o=1, reg_adr_o=0, reg_dat_o=0, reg_we_o=0, busy_o=0, state IDLE.
//  Input path and latency:
//   - 2-FF synchroniser, then glitch filter; filtered level changes only after FILTER equal samples.
//   - Pad-to-filtered latency is 2+FILTER cycles.
//   - Bus timing requirement: SCL high and low phases each >= FILTER+4 clocks.
//  Bus event detection:
//   - Edge detect operates on the filtered signals.
//   - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
//   - START/STOP are honoured in every state.
//  Data bit timing:
//   - SDA is sampled on filtered SCL rise.
//   - sda_padoen_o changes only the cycle after a filtered SCL fall.
//  State machine:
//   - IDLE -> ADDR on START.
//   - ADDR shifts 8 bits, MSB first.
//   - On SCL fall after bit 8: if addr[7:1] == SLV_ADDR, go to A_ACK and pull SDA low; else go to WAIT_STOP with SDA released.
//   - A_ACK releases SDA on the next SCL fall. Next state is PTR if R/W=0; TX if R/W=1, loading reg_dat_i into the tx shifter that cycle.
//   - PTR: 8-bit byte received; reg_adr_o <= byte[AW-1:0]; ACK; -> WDATA.
//   - WDATA: byte received; at SCL fall after bit 8, reg_dat_o <= byte, reg_we_o=1 (1 cycle), ACK driven.
//     reg_adr_o increments the cycle after reg_we_o. Stay in WDATA.
//   - TX: bit driven after each SCL fall (sda_padoen_o = bit); SDA released after bit 8.
//     The master ACK/NACK is sampled on the 9th SCL rise. reg_adr_o increments on that rise.
//     ACK (0): reload reg_dat_i on the next SCL fall, continue TX. NACK (1): go to WAIT_STOP.
//   - WAIT_STOP: SDA released; ignore data until START/STOP.
//  Pointer: wraps modulo 2**AW (2**AW-1 -> 0).
//  Repeated START in any state -> ADDR, pointer retained, SDA released.
//  STOP in any state -> IDLE, SDA released. A partial byte (<8 bits) is discarded; no reg_we_o.
//  Simultaneous events: a START/STOP seen in the same cycle as a bit-8 completion wins; no reg_we_o is issued.
//  Reset asserted mid-transfer releases SDA immediately (asynchronously).
// TESTING
//  1. Write 0xA0, 0x02, 0x5A, 0xC3, STOP -> 4 ACKs; reg_we_o pulses (adr 2, 0x5A), then (adr 3, 0xC3); final reg_adr_o=4.
//  2. Write 0xA0, 0x07; Sr; 0xA1; reg file[7]=0x3C, [0]=0x81; master ACK then NACK
//     -> SDA carries 0x3C then 0x81 (pointer wraps); SDA released after NACK; reg_adr_o=1.
//  3. Address 0xA2 (0x51), 2 data bytes -> no ACK anywhere, no reg_we_o; busy_o=1 until STOP, then 0.
//  4. SDA low glitch of FILTER-1 cycles while SCL high -> no START; state stays IDLE, busy_o=0.
//  5. STOP after 3 data bits of a WDATA byte -> no reg_we_o; IDLE; busy_o=0.
//  6. arst_i=1 during the address ACK (sda_padoen_o=0) -> sda_padoen_o=1 before the next clock edge;
//     after release, a full write (scenario 1) works.

Source files
------------

// File: rtl/i2c_slave_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regs
// Description : I2C target exposing a 2**AW-byte register space through an
//               auto-incrementing pointer. SCL/SDA are oversampled on
//               wb_clk_i, glitch-filtered, and decoded into START/STOP and
//               data-bit events. No clock stretching.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regs #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         AW       = 3,
    parameter int         FILTER   = 3
) (
    input  logic          wb_clk_i,
    input  logic          arst_i,
    input  logic          scl_pad_i,
    input  logic          sda_pad_i,
    output logic          scl_pad_o,
    output logic          scl_padoen_o,
    output logic          sda_pad_o,
    output logic          sda_padoen_o,
    output logic [AW-1:0] reg_adr_o,
    output logic [7:0]    reg_dat_o,
    output logic          reg_we_o,
    input  logic [7:0]    reg_dat_i,
    output logic          busy_o
);

    localparam int c_FILT_W = (FILTER > 1) ? $clog2(FILTER) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_A_ACK, S_PTR, S_WDATA, S_TX, S_WAIT_STOP
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0] w_pad;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_filt;
    logic [1:0] r_filt_d;

    assign w_pad = {sda_pad_i, scl_pad_i};

    // Two-stage synchroniser; idle bus level is high
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= w_pad;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic                r_lvl;
        logic [c_FILT_W-1:0] r_cnt;

        // Accept a new level only after FILTER consecutive differing samples
        always_ff @(posedge wb_clk_i or posedge arst_i) begin
            if (arst_i) begin
                r_lvl <= 1'b1;
                r_cnt <= '0;
            end else if (r_sync2[gi] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == c_FILT_W'(FILTER - 1)) begin
                r_lvl <= r_sync2[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_filt[gi] = r_lvl;
    end

    // Previous filtered levels for edge detection
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) r_filt_d <= 2'b11;
        else        r_filt_d <= w_filt;
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = w_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~w_filt[0] & r_filt_d[0];
    assign w_start    = w_filt[0] & r_filt_d[0] & r_filt_d[1] & ~w_filt[1];
    assign w_stop     = w_filt[0] & r_filt_d[0] & ~r_filt_d[1] & w_filt[1];

    // Protocol state; r_bit counts SCL rises within a byte (9 = ACK phase)
    state_t        r_state, w_state_nxt;
    logic [3:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_oen, w_oen_nxt;
    logic          r_rw, w_rw_nxt;
    logic [AW-1:0] r_adr, w_adr_nxt;
    logic [7:0]    r_dat, w_dat_nxt;
    logic          r_we, w_we_nxt;

    // State and datapath registers; reset releases SDA immediately
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= S_IDLE;
            r_bit   <= '0;
            r_shift <= '0;
            r_oen   <= 1'b1;
            r_rw    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_oen   <= w_oen_nxt;
            r_rw    <= w_rw_nxt;
            r_adr   <= w_adr_nxt;
            r_dat   <= w_dat_nxt;
            r_we    <= w_we_nxt;
        end
    end

    // Next-state: bus START/STOP take priority over any bit activity
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_oen_nxt   = r_oen;
        w_rw_nxt    = r_rw;
        w_adr_nxt   = r_we ? r_adr + 1'b1 : r_adr;
        w_dat_nxt   = r_dat;
        w_we_nxt    = 1'b0;

        if (w_start) begin
            w_state_nxt = S_ADDR;
            w_bit_nxt   = '0;
            w_oen_nxt   = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_bit_nxt   = '0;
            w_oen_nxt   = 1'b1;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise) begin
                        if (r_bit < 4'd8) w_shift_nxt = {r_shift[6:0], w_filt[1]};
                        w_bit_nxt = r_bit + 1'b1;
                    end else if (w_scl_fall && r_bit == 4'd8) begin
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == SLV_ADDR) begin
                                w_state_nxt = S_A_ACK;
                                w_oen_nxt   = 1'b0;
                                w_rw_nxt    = r_shift[0];
                            end else begin
                                w_state_nxt = S_WAIT_STOP;
                            end
                        end else begin
                            w_oen_nxt = 1'b0;
                            if (r_state == S_PTR) begin
                                w_adr_nxt = r_shift[AW-1:0];
                            end else begin
                                w_dat_nxt = r_shift;
                                w_we_nxt  = 1'b1;
                            end
                        end
                    end else if (w_scl_fall && r_bit == 4'd9) begin
                        w_oen_nxt = 1'b1;
                        w_bit_nxt = '0;
                        if (r_state == S_PTR) w_state_nxt = S_WDATA;
                    end
                end
                S_A_ACK: begin
                    if (w_scl_fall) begin
                        w_bit_nxt = '0;
                        if (r_rw) begin
                            w_state_nxt = S_TX;
                            w_shift_nxt = reg_dat_i;
                            w_oen_nxt   = reg_dat_i[7];
                        end else begin
                            w_state_nxt = S_PTR;
                            w_oen_nxt   = 1'b1;
                        end
                    end
                end
                S_TX: begin
                    if (w_scl_rise) begin
                        w_bit_nxt = r_bit + 1'b1;
                        if (r_bit == 4'd8) begin
                            w_adr_nxt = r_adr + 1'b1;
                            if (w_filt[1]) w_state_nxt = S_WAIT_STOP;
                        end
                    end else if (w_scl_fall) begin
                        if (r_bit == 4'd9) begin
                            w_shift_nxt = reg_dat_i;
                            w_oen_nxt   = reg_dat_i[7];
                            w_bit_nxt   = '0;
                        end else if (r_bit == 4'd8) begin
                            w_oen_nxt = 1'b1;
                        end else if (r_bit != 4'd0) begin
                            w_oen_nxt   = r_shift[6];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    w_oen_nxt = 1'b1;
                end
            endcase
        end
    end

    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = r_oen;
    assign reg_adr_o    = r_adr;
    assign reg_dat_o    = r_dat;
    assign reg_we_o     = r_we;
    assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_regs
// Description : Directed self-checking bench for i2c_slave_regs with a
//               bit-level I2C master model and an open-drain bus model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regs;

    localparam int AW     = 3;
    localparam int FILTER = 3;
    localparam int Q      = 10;   // clocks per quarter SCL period

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          scl_m = 1'b1;
    logic          sda_m = 1'b1;
    logic          scl_bus, sda_bus;
    logic          scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
    logic [AW-1:0] reg_adr_o;
    logic [7:0]    reg_dat_o;
    logic          reg_we_o;
    logic [7:0]    reg_dat_i;
    logic          busy_o;

    logic [7:0]    rf [0:7];
    logic [AW-1:0] wr_adr [$];
    logic [7:0]    wr_dat [$];
    logic          oen_low_seen = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign scl_bus   = scl_padoen_o ? scl_m : (scl_m & scl_pad_o);
    assign sda_bus   = sda_padoen_o ? sda_m : (sda_m & sda_pad_o);
    assign reg_dat_i = rf[reg_adr_o];

    i2c_slave_regs #(.SLV_ADDR(7'h50), .AW(AW), .FILTER(FILTER)) dut (
        .wb_clk_i     (clk),
        .arst_i       (arst),
        .scl_pad_i    (scl_bus),
        .sda_pad_i    (sda_bus),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen_o),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .reg_adr_o    (reg_adr_o),
        .reg_dat_o    (reg_dat_o),
        .reg_we_o     (reg_we_o),
        .reg_dat_i    (reg_dat_i),
        .busy_o       (busy_o)
    );

    // Record every write strobe and any SDA pull-down
    always @(negedge clk) begin
        if (reg_we_o) begin
            wr_adr.push_back(reg_adr_o);
            wr_dat.push_back(reg_dat_o);
        end
        if (!sda_padoen_o) oen_low_seen = 1'b1;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b0; wait_q(); scl_m = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_q(); sda_m = 1'b1; wait_q(); scl_m = 1'b1; wait_q(); sda_m = 1'b0; wait_q(); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_q(); sda_m = 1'b0; wait_q(); scl_m = 1'b1; wait_q(); sda_m = 1'b1; wait_q(); wait_q();
    endtask

    // Entered and left with SCL low
    task automatic clk_bit(input logic b, output logic s);
        wait_q(); sda_m = b; wait_q(); scl_m = 1'b1; wait_q(); s = sda_bus; wait_q(); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(mack, s);
    endtask

    task automatic test_reset();
        arst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (sda_padoen_o !== 1'b1) begin n_errors++; $display("FAIL reset_sda_oen got %b want 1", sda_padoen_o); end
        n_checks++; if (reg_adr_o !== 3'd0) begin n_errors++; $display("FAIL reset_adr got %0d want 0", reg_adr_o); end
        n_checks++; if (reg_dat_o !== 8'h00) begin n_errors++; $display("FAIL reset_dat got %h want 00", reg_dat_o); end
        n_checks++; if (reg_we_o !== 1'b0) begin n_errors++; $display("FAIL reset_we got %b want 0", reg_we_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_checks++; if (scl_padoen_o !== 1'b1) begin n_errors++; $display("FAIL reset_scl_oen got %b want 1", scl_padoen_o); end
        n_checks++; if ({scl_pad_o, sda_pad_o} !== 2'b00) begin n_errors++; $display("FAIL reset_pad_o got %b want 00", {scl_pad_o, sda_pad_o}); end
        arst = 1'b0;
        wait_q();
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        logic [AW-1:0] ad0, ad1;
        logic [7:0] d0, d1;
        wr_adr.delete(); wr_dat.delete();
        bus_start();
        write_byte(8'hA0, a0);
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL wr_busy_mid got %b want 1", busy_o); end
        write_byte(8'h02, a1);
        write_byte(8'h5A, a2);
        write_byte(8'hC3, a3);
        bus_stop();
        n_checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_errors++; $display("FAIL wr_acks got %b want 0000", {a0, a1, a2, a3}); end
        n_checks++; if (wr_dat.size() !== 2) begin n_errors++; $display("FAIL wr_count got %0d want 2", wr_dat.size()); end
        ad0 = (wr_adr.size() > 0) ? wr_adr[0] : 'x;
        d0  = (wr_dat.size() > 0) ? wr_dat[0] : 'x;
        ad1 = (wr_adr.size() > 1) ? wr_adr[1] : 'x;
        d1  = (wr_dat.size() > 1) ? wr_dat[1] : 'x;
        n_checks++; if (ad0 !== 3'd2 || d0 !== 8'h5A) begin n_errors++; $display("FAIL wr_first got adr %0d dat %h want adr 2 dat 5a", ad0, d0); end
        n_checks++; if (ad1 !== 3'd3 || d1 !== 8'hC3) begin n_errors++; $display("FAIL wr_second got adr %0d dat %h want adr 3 dat c3", ad1, d1); end
        n_checks++; if (reg_adr_o !== 3'd4) begin n_errors++; $display("FAIL wr_final_adr got %0d want 4", reg_adr_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL wr_busy_end got %b want 0", busy_o); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] b0, b1;
        rf[7] = 8'h3C; rf[0] = 8'h81;
        wr_adr.delete(); wr_dat.delete();
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'h07, a1);
        n_checks++; if (reg_adr_o !== 3'd7) begin n_errors++; $display("FAIL rd_ptr got %0d want 7", reg_adr_o); end
        bus_rstart();
        write_byte(8'hA1, a2);
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        n_checks++; if (sda_padoen_o !== 1'b1) begin n_errors++; $display("FAIL rd_release got %b want 1", sda_padoen_o); end
        bus_stop();
        n_checks++; if ({a0, a1, a2} !== 3'b000) begin n_errors++; $display("FAIL rd_acks got %b want 000", {a0, a1, a2}); end
        n_checks++; if (b0 !== 8'h3C) begin n_errors++; $display("FAIL rd_byte0 got %h want 3c", b0); end
        n_checks++; if (b1 !== 8'h81) begin n_errors++; $display("FAIL rd_byte1 got %h want 81", b1); end
        n_checks++; if (reg_adr_o !== 3'd1) begin n_errors++; $display("FAIL rd_final_adr got %0d want 1", reg_adr_o); end
        n_checks++; if (wr_dat.size() !== 0) begin n_errors++; $display("FAIL rd_no_write got %0d want 0", wr_dat.size()); end
    endtask

    task automatic test_nomatch();
        logic a0, a1, a2;
        wr_adr.delete(); wr_dat.delete();
        oen_low_seen = 1'b0;
        bus_start();
        write_byte(8'hA2, a0);
        write_byte(8'h11, a1);
        write_byte(8'h22, a2);
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL nm_busy_mid got %b want 1", busy_o); end
        bus_stop();
        n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_errors++; $display("FAIL nm_acks got %b want 111", {a0, a1, a2}); end
        n_checks++; if (oen_low_seen !== 1'b0) begin n_errors++; $display("FAIL nm_sda_driven got %b want 0", oen_low_seen); end
        n_checks++; if (wr_dat.size() !== 0) begin n_errors++; $display("FAIL nm_no_write got %0d want 0", wr_dat.size()); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL nm_busy_end got %b want 0", busy_o); end
        n_checks++; if (reg_adr_o !== 3'd1) begin n_errors++; $display("FAIL nm_adr got %0d want 1", reg_adr_o); end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        sda_m = 1'b0;
        repeat (FILTER - 1) @(negedge clk);
        sda_m = 1'b1;
        wait_q(); wait_q();
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL glitch_busy got %b want 0", busy_o); end
    endtask

    task automatic test_partial();
        logic a0, a1, s;
        wr_adr.delete(); wr_dat.delete();
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'h01, a1);
        for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
        bus_stop();
        n_checks++; if ({a0, a1} !== 2'b00) begin n_errors++; $display("FAIL part_acks got %b want 00", {a0, a1}); end
        n_checks++; if (wr_dat.size() !== 0) begin n_errors++; $display("FAIL part_no_write got %0d want 0", wr_dat.size()); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL part_busy got %b want 0", busy_o); end
        n_checks++; if (reg_adr_o !== 3'd1) begin n_errors++; $display("FAIL part_adr got %0d want 1", reg_adr_o); end
    endtask

    task automatic test_reset_mid();
        logic s;
        logic found;
        logic [7:0] addr_byte;
        addr_byte = 8'hA0;
        bus_start();
        for (int i = 7; i >= 0; i--) clk_bit(addr_byte[i], s);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (!sda_padoen_o) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL rm_ack_driven got %b want 1", found); end
        #1 arst = 1'b1;
        #1;
        n_checks++; if (sda_padoen_o !== 1'b1) begin n_errors++; $display("FAIL rm_async_release got %b want 1", sda_padoen_o); end
        n_checks++; if (reg_adr_o !== 3'd0) begin n_errors++; $display("FAIL rm_adr got %0d want 0", reg_adr_o); end
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        arst = 1'b0;
        wait_q();
        test_write();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_nomatch();
        test_glitch();
        test_partial();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
